obstacle_guard: RTL

Downstream consumer of the ultrasonic ranger's 16-bit distance_cm on the RC car SoC. It smooths the readings with a power-of-two moving average. It then classifies the smoothed distance into CLEAR / WARN / STOP zones with hysteresis and debounce. A watchdog forces a safe stop when measurements stop arriving. Its outputs drive the motor controller's slow/stop inputs.

---
 rtl/obstacle_pkg.sv | 20 ++
 rtl/obstacle_guard_if.sv | 27 ++
 rtl/moving_avg_pow2.sv | 78 +++++++
 rtl/obstacle_guard.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// Shared definitions for the obstacle guard: zone encoding, distance width
// and the running-sum width helper.
package obstacle_pkg;

   localparam int unsigned DIST_W = 16;

   // Encoding is ordered by severity for CLEAR < WARN < STOP; FAULT sits above all.
   typedef enum logic [1:0] {
      ZONE_CLEAR = 2'b00,
      ZONE_WARN  = 2'b01,
      ZONE_STOP  = 2'b10,
      ZONE_FAULT = 2'b11
   } zone_e;

   // Sum of 2^avg_log2 DIST_W-bit samples never overflows this width.
   function automatic int unsigned sum_w(input int unsigned avg_log2);
      return DIST_W + avg_log2;
   endfunction

endpackage

// File: rtl/obstacle_guard_if.sv
// Bus between the ultrasonic ranger / motor controller side and obstacle_guard.
//   distance_cm, dist_valid : measurement in
//   avg_cm, avg_valid       : smoothed distance out
//   zone, slow, stop, fault : classification out
interface obstacle_guard_if;
   import obstacle_pkg::*;

   logic [DIST_W-1:0] distance_cm;
   logic              dist_valid;
   logic [DIST_W-1:0] avg_cm;
   logic              avg_valid;
   logic [1:0]        zone;
   logic              slow;
   logic              stop;
   logic              fault;

   modport master (
      output distance_cm, dist_valid,
      input  avg_cm, avg_valid, zone, slow, stop, fault
   );

   modport slave (
      input  distance_cm, dist_valid,
      output avg_cm, avg_valid, zone, slow, stop, fault
   );

endinterface

// File: rtl/moving_avg_pow2.sv
// Power-of-two moving average over a circular sample buffer.
//   clk, reset_p : clock, synchronous active-high reset
//   in_valid     : new sample on in_data
//   flush        : with in_valid, discard the window and start a new one with in_data
//   avg_cm       : registered sum >> AVG_LOG2
//   avg_valid    : window completely filled since reset/flush
module moving_avg_pow2
   import obstacle_pkg::*;
#(
   parameter int unsigned AVG_LOG2 = 2
) (
   input  logic              clk,
   input  logic              reset_p,
   input  logic              in_valid,
   input  logic              flush,
   input  logic [DIST_W-1:0] in_data,
   output logic [DIST_W-1:0] avg_cm,
   output logic              avg_valid
);

   localparam int unsigned WIN    = 1 << AVG_LOG2;
   localparam int unsigned SUM_W  = sum_w(AVG_LOG2);
   localparam int unsigned FILL_W = AVG_LOG2 + 1;

   logic [DIST_W-1:0]   mem_q [WIN];
   logic [DIST_W-1:0]   mem_d [WIN];
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic [AVG_LOG2-1:0] wptr_q, wptr_d;
   logic [FILL_W-1:0]   fill_q, fill_d;
   logic [DIST_W-1:0]   avg_q, avg_d;
   logic                avg_valid_q, avg_valid_d;

   // Window update: replace oldest entry and adjust the running sum.
   always_comb begin
      mem_d  = mem_q;
      sum_d  = sum_q;
      wptr_d = wptr_q;
      fill_d = fill_q;
      if (in_valid) begin
         if (flush) begin
            mem_d    = '{default: '0};
            mem_d[0] = in_data;
            sum_d    = SUM_W'(in_data);
            wptr_d   = AVG_LOG2'(1);
            fill_d   = FILL_W'(1);
         end else begin
            mem_d[wptr_q] = in_data;
            sum_d         = sum_q + SUM_W'(in_data) - SUM_W'(mem_q[wptr_q]);
            wptr_d        = wptr_q + AVG_LOG2'(1);
            if (fill_q != FILL_W'(WIN)) fill_d = fill_q + FILL_W'(1);
         end
      end
      avg_d       = DIST_W'(sum_d >> AVG_LOG2);
      avg_valid_d = (fill_d == FILL_W'(WIN));
   end

   always_ff @(posedge clk) begin
      if (reset_p) begin
         mem_q       <= '{default: '0};
         sum_q       <= '0;
         wptr_q      <= '0;
         fill_q      <= '0;
         avg_q       <= '0;
         avg_valid_q <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         sum_q       <= sum_d;
         wptr_q      <= wptr_d;
         fill_q      <= fill_d;
         avg_q       <= avg_d;
         avg_valid_q <= avg_valid_d;
      end
   end

   assign avg_cm    = avg_q;
   assign avg_valid = avg_valid_q;

endmodule

// File: rtl/obstacle_guard.sv
// Obstacle guard: smooths ultrasonic distances, classifies them into
// CLEAR/WARN/STOP with hysteresis and debounce, and forces FAULT when
// measurements stop arriving.
//   clk, reset_p : clock, synchronous active-high reset
//   bus (slave)  : distance_cm/dist_valid in; avg_cm, avg_valid, zone,
//                  slow, stop, fault out
// Optional build macro OBSTACLE_MEDIAN3_EN inserts a median-of-3 prefilter
// ahead of the averager (one extra cycle of latency).
module obstacle_guard
   import obstacle_pkg::*;
#(
   parameter int unsigned       AVG_LOG2    = 2,
   parameter logic [DIST_W-1:0] STOP_CM     = 16'd15,
   parameter logic [DIST_W-1:0] WARN_CM     = 16'd40,
   parameter logic [DIST_W-1:0] HYST_CM     = 16'd3,
   parameter int unsigned       DEBOUNCE    = 3,
   parameter logic [31:0]       TIMEOUT_CYC = 32'd10_000_000
) (
   input  logic            clk,
   input  logic            reset_p,
   obstacle_guard_if.slave bus
);

   localparam int unsigned       DB_W      = $clog2(DEBOUNCE + 1);
   localparam logic [DIST_W-1:0] STOP_EXIT = STOP_CM + HYST_CM;
   localparam logic [DIST_W-1:0] WARN_EXIT = WARN_CM + HYST_CM;
   localparam logic [31:0]       WD_LIMIT  = TIMEOUT_CYC - 32'd1;

   zone_e             zone_q, zone_d, tgt_q, tgt_d, raw, rel_tgt;
   logic [DB_W-1:0]   dbc_q, dbc_d, dbc_inc;
   logic              seeded_q, seeded_d;
   logic [31:0]       wd_q, wd_d;
   logic              upd_q;
   logic              slow_q, slow_d, stop_q, stop_d, fault_q, fault_d;
   logic              rel_ok;
   logic              flush_now;
   logic              avg_in_vld, avg_flush;
   logic [DIST_W-1:0] avg_in, avg_cm_w;
   logic              avg_valid_w;

   function automatic zone_e severity(input logic [DIST_W-1:0] a);
      if (a <= STOP_CM) return ZONE_STOP;
      if (a <= WARN_CM) return ZONE_WARN;
      return ZONE_CLEAR;
   endfunction

   // First measurement after a timeout restarts the window.
   assign flush_now = bus.dist_valid && (zone_q == ZONE_FAULT);

`ifdef OBSTACLE_MEDIAN3_EN
   logic [DIST_W-1:0] h0_q, h0_d, h1_q, h1_d, med_q, med_d;
   logic [1:0]        hcnt_q, hcnt_d;
   logic              med_vld_q, med_flush_q;

   function automatic logic [DIST_W-1:0] med3(input logic [DIST_W-1:0] a,
                                              input logic [DIST_W-1:0] b,
                                              input logic [DIST_W-1:0] c);
      if (a > b) return (b > c) ? b : ((a > c) ? c : a);
      return (a > c) ? a : ((b > c) ? c : b);
   endfunction

   // Until three samples are known the newest sample passes straight through.
   always_comb begin
      h0_d   = h0_q;
      h1_d   = h1_q;
      hcnt_d = hcnt_q;
      med_d  = med_q;
      if (bus.dist_valid) begin
         med_d = bus.distance_cm;
         h0_d  = bus.distance_cm;
         if (flush_now) begin
            h1_d   = '0;
            hcnt_d = 2'd1;
         end else begin
            if (hcnt_q == 2'd2) med_d = med3(h1_q, h0_q, bus.distance_cm);
            else                hcnt_d = hcnt_q + 2'd1;
            h1_d = h0_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset_p) begin
         h0_q        <= '0;
         h1_q        <= '0;
         hcnt_q      <= '0;
         med_q       <= '0;
         med_vld_q   <= 1'b0;
         med_flush_q <= 1'b0;
      end else begin
         h0_q        <= h0_d;
         h1_q        <= h1_d;
         hcnt_q      <= hcnt_d;
         med_q       <= med_d;
         med_vld_q   <= bus.dist_valid;
         med_flush_q <= flush_now;
      end
   end

   always_comb begin
      avg_in     = med_q;
      avg_in_vld = med_vld_q;
      avg_flush  = med_flush_q;
   end
`else
   always_comb begin
      avg_in     = bus.distance_cm;
      avg_in_vld = bus.dist_valid;
      avg_flush  = flush_now;
   end
`endif

   moving_avg_pow2 #(.AVG_LOG2(AVG_LOG2)) u_avg (
      .clk       (clk),
      .reset_p   (reset_p),
      .in_valid  (avg_in_vld),
      .flush     (avg_flush),
      .in_data   (avg_in),
      .avg_cm    (avg_cm_w),
      .avg_valid (avg_valid_w)
   );

   // Zone FSM and watchdog next-state.
   always_comb begin
      zone_d   = zone_q;
      tgt_d    = tgt_q;
      dbc_d    = dbc_q;
      dbc_inc  = DB_W'(1);
      seeded_d = seeded_q;
      raw      = severity(avg_cm_w);
      rel_ok   = 1'b0;
      rel_tgt  = ZONE_CLEAR;
      wd_d     = (wd_q == WD_LIMIT) ? wd_q : wd_q + 32'd1;
      if (bus.dist_valid) wd_d = '0;

      // Relaxation target for this average (CLEAR preferred from STOP).
      if (avg_cm_w > WARN_EXIT) begin
         rel_ok  = (zone_q != ZONE_CLEAR);
         rel_tgt = ZONE_CLEAR;
      end else if (avg_cm_w > STOP_EXIT) begin
         rel_ok  = (zone_q == ZONE_STOP);
         rel_tgt = ZONE_WARN;
      end
      if ((dbc_q != '0) && (tgt_q == rel_tgt)) dbc_inc = dbc_q + DB_W'(1);

      if (flush_now) begin
         zone_d   = ZONE_STOP;
         dbc_d    = '0;
         seeded_d = 1'b0;
      end else if (!bus.dist_valid && (wd_q == WD_LIMIT)) begin
         zone_d = ZONE_FAULT;
         dbc_d  = '0;
      end else if (upd_q && avg_valid_w) begin
         // A freshly filled window adopts its raw zone without debounce.
         if (!seeded_q) begin
            zone_d   = raw;
            seeded_d = 1'b1;
         end else if (raw > zone_q) begin
            zone_d = raw;
            dbc_d  = '0;
         end else if (!rel_ok) begin
            dbc_d = '0;
         end else if (dbc_inc == DB_W'(DEBOUNCE)) begin
            zone_d = rel_tgt;
            dbc_d  = '0;
         end else begin
            dbc_d = dbc_inc;
            tgt_d = rel_tgt;
         end
      end

      // avg_valid is only ever low while zone is STOP, so zone alone decides stop.
      slow_d  = (zone_d == ZONE_WARN);
      stop_d  = (zone_d == ZONE_STOP) || (zone_d == ZONE_FAULT);
      fault_d = (zone_d == ZONE_FAULT);
   end

   always_ff @(posedge clk) begin
      if (reset_p) begin
         zone_q   <= ZONE_STOP;
         tgt_q    <= ZONE_CLEAR;
         dbc_q    <= '0;
         seeded_q <= 1'b0;
         wd_q     <= '0;
         upd_q    <= 1'b0;
         slow_q   <= 1'b0;
         stop_q   <= 1'b1;
         fault_q  <= 1'b0;
      end else begin
         zone_q   <= zone_d;
         tgt_q    <= tgt_d;
         dbc_q    <= dbc_d;
         seeded_q <= seeded_d;
         wd_q     <= wd_d;
         upd_q    <= avg_in_vld;
         slow_q   <= slow_d;
         stop_q   <= stop_d;
         fault_q  <= fault_d;
      end
   end

   assign bus.avg_cm    = avg_cm_w;
   assign bus.avg_valid = avg_valid_w;
   assign bus.zone      = zone_q;
   assign bus.slow      = slow_q;
   assign bus.stop      = stop_q;
   assign bus.fault     = fault_q;

endmodule
